// File: rtl/ro_puf_controller_pkg.sv
// Shared types and defaults for the ring-oscillator PUF controller.
// FSM state encoding, default bank geometry and a small elaboration helper.
package ro_puf_controller_pkg;

  localparam int DEF_N_RO  = 8;
  localparam int DEF_SEL_W = 3;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESET_RO = 3'd1,
    ST_MEASURE  = 3'd2,
    ST_COMPARE  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_puf_controller_if.sv
// Host-side challenge/response bundle: start + two RO indices in, status and counts out.
// The master drives the challenge, the slave (controller) returns the result.
interface ro_puf_controller_if
  import ro_puf_controller_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic [SEL_W-1:0] challenge_a;
  logic [SEL_W-1:0] challenge_b;
  logic             busy;
  logic             done;
  logic             response;
  logic             error;
  logic             saturated;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport master (
    output start, challenge_a, challenge_b,
    input  busy, done, response, error, saturated, count_a, count_b
  );

  modport slave (
    input  start, challenge_a, challenge_b,
    output busy, done, response, error, saturated, count_a, count_b
  );
endinterface

// File: rtl/ro_puf_controller_edge_counter.sv
// Counts rising edges of one asynchronous RO output: 2-flop sync, prev-flop edge detect,
// clear/enable saturating counter. Edges reach the counter 3 clk after they occur.
module ro_puf_controller_edge_counter
  import ro_puf_controller_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ro,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);
  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_ro};
      r_prev <= r_sync[1];
    end
  end

  assign w_rise = r_sync[1] & ~r_prev;
  assign o_sat  = &r_cnt;

  // Sticks at all-ones instead of wrapping so a fast RO cannot alias to a small count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && w_rise && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ro_puf_controller.sv
// One challenge/response evaluation: hold selected ROs in reset, count edges over a fixed window,
// compare. done arrives RST_CYCLES+WINDOW+2 cycles after start (1 cycle for an a==b challenge).
module ro_puf_controller
  import ro_puf_controller_pkg::*;
#(
  parameter int N_RO       = DEF_N_RO,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WINDOW     = 1000,
  parameter int RST_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  ro_puf_controller_if.slave  host_if,
  input  logic [N_RO-1:0]     i_ro_out,
  output logic                o_ro_enable,
  output logic [N_RO-1:0]     o_ro_rst
);
  localparam int TMR_W = $clog2(max_int(WINDOW, RST_CYCLES) + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [SEL_W-1:0] r_sel_a;
  logic [SEL_W-1:0] r_sel_b;
  logic             w_accept;
  logic             w_same;
  logic             w_tmr_zero;

  logic             w_busy;
  logic             w_done;
  logic             w_ro_enable;
  logic [N_RO-1:0]  w_ro_rst;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  logic [CNT_W-1:0] w_cnt_a;
  logic [CNT_W-1:0] w_cnt_b;
  logic             w_sat_a;
  logic             w_sat_b;

  logic             r_response;
  logic             r_error;
  logic             r_saturated;
  logic [CNT_W-1:0] r_count_a;
  logic [CNT_W-1:0] r_count_b;

  assign w_accept   = (r_state == ST_IDLE) && host_if.start;
  assign w_same     = (host_if.challenge_a == host_if.challenge_b);
  assign w_tmr_zero = (r_tmr == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_state_nxt = w_same ? ST_DONE : ST_RESET_RO;
      ST_RESET_RO: if (w_tmr_zero) w_state_nxt = ST_MEASURE;
      ST_MEASURE:  if (w_tmr_zero) w_state_nxt = ST_COMPARE;
      ST_COMPARE:  w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_ro_enable = 1'b0;
    w_ro_rst    = '1;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: w_busy = 1'b0;
      ST_RESET_RO: begin
        w_ro_enable = 1'b1;
        w_cnt_clr   = 1'b1;
      end
      ST_MEASURE: begin
        w_ro_enable       = 1'b1;
        w_cnt_en          = 1'b1;
        w_ro_rst[r_sel_a] = 1'b0;
        w_ro_rst[r_sel_b] = 1'b0;
      end
      ST_COMPARE: ;
      ST_DONE:    w_done = 1'b1;
      default:    w_busy = 1'b0;
    endcase
  end

  // Single down-counter shared by the reset hold and the measurement window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmr <= '0;
    end else if (w_accept && !w_same) begin
      r_tmr <= TMR_W'(RST_CYCLES - 1);
    end else if ((r_state == ST_RESET_RO) && w_tmr_zero) begin
      r_tmr <= TMR_W'(WINDOW - 1);
    end else if (!w_tmr_zero) begin
      r_tmr <= r_tmr - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else if (w_accept) begin
      r_sel_a <= host_if.challenge_a;
      r_sel_b <= host_if.challenge_b;
    end
  end

  ro_puf_controller_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ro  (i_ro_out[r_sel_a]),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt_a),
    .o_sat (w_sat_a)
  );

  ro_puf_controller_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ro  (i_ro_out[r_sel_b]),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt_b),
    .o_sat (w_sat_b)
  );

  // Results keep the previous evaluation visible until the next COMPARE overwrites them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_response  <= 1'b0;
      r_error     <= 1'b0;
      r_saturated <= 1'b0;
      r_count_a   <= '0;
      r_count_b   <= '0;
    end else if (w_accept && w_same) begin
      r_response  <= 1'b0;
      r_error     <= 1'b1;
      r_saturated <= 1'b0;
      r_count_a   <= '0;
      r_count_b   <= '0;
    end else if (r_state == ST_COMPARE) begin
      r_response  <= (w_cnt_a > w_cnt_b);
      r_error     <= 1'b0;
      r_saturated <= w_sat_a | w_sat_b;
      r_count_a   <= w_cnt_a;
      r_count_b   <= w_cnt_b;
    end
  end

  assign host_if.busy      = w_busy;
  assign host_if.done      = w_done;
  assign host_if.response  = r_response;
  assign host_if.error     = r_error;
  assign host_if.saturated = r_saturated;
  assign host_if.count_a   = r_count_a;
  assign host_if.count_b   = r_count_b;
  assign o_ro_enable       = w_ro_enable;
  assign o_ro_rst          = w_ro_rst;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: RO bank modelled as free-running square waves with per-RO toggle periods;
// expected counts come from edges-per-window arithmetic on those periods.
module tb_ro_puf_controller;
  localparam int W        = 40;
  localparam int RC       = 2;
  localparam int DONE_CYC = RC + W + 2;
  localparam int RUN_CYC  = DONE_CYC + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ro_out = '0;
  logic       ro_en, ro_en_s;
  logic [7:0] ro_rst, ro_rst_s;

  int n_err = 0;
  int n_chk = 0;

  int period [8];
  int ro_cnt [8];
  bit tie_mode = 1'b0;

  int         ev_done_cyc, ev_ndone, ev_busy_cyc;
  bit         ev_en_seen;
  logic [7:0] ev_rst_mid;

  ro_puf_controller_if #(.SEL_W(3), .CNT_W(16)) host ();
  ro_puf_controller_if #(.SEL_W(3), .CNT_W(4))  host_s ();

  ro_puf_controller #(.N_RO(8), .SEL_W(3), .CNT_W(16), .WINDOW(W), .RST_CYCLES(RC)) dut (
    .i_clk(clk), .i_rst(rst), .host_if(host), .i_ro_out(ro_out),
    .o_ro_enable(ro_en), .o_ro_rst(ro_rst)
  );

  ro_puf_controller #(.N_RO(8), .SEL_W(3), .CNT_W(4), .WINDOW(W), .RST_CYCLES(RC)) dut_s (
    .i_clk(clk), .i_rst(rst), .host_if(host_s), .i_ro_out(ro_out),
    .o_ro_enable(ro_en_s), .o_ro_rst(ro_rst_s)
  );

  always #5 clk = ~clk;

  // Each RO toggles every period[i] clk cycles; period 0 holds it low.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (period[i] == 0) begin
        ro_out[i] = 1'b0;
        ro_cnt[i] = 0;
      end else begin
        ro_cnt[i] = ro_cnt[i] + 1;
        if (ro_cnt[i] >= period[i]) begin
          ro_out[i] = ~ro_out[i];
          ro_cnt[i] = 0;
        end
      end
    end
    if (tie_mode) ro_out[3] = ro_out[2];
  end

  // A W-cycle window of a square wave with half-period p holds about W/(2p) rising edges;
  // one may be lost to synchronizer latency at the end of the window.
  function automatic int edges_lo(input int p);
    int n;
    n = W / (2 * p);
    return (n > 0) ? n - 1 : 0;
  endfunction

  function automatic int edges_hi(input int p);
    return (W + 2 * p - 1) / (2 * p);
  endfunction

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    for (int i = 0; i < 8; i++) period[i] = 0;
    period[0] = p0; period[1] = p1; period[2] = p2; period[3] = p3;
  endtask

  // Launches one evaluation on the main DUT and observes RUN_CYC cycles; challenges are swapped
  // right after launch and start is re-pulsed at restart_at, both of which must be ignored.
  task automatic run_eval(input logic [2:0] a, input logic [2:0] b, input int restart_at);
    host.start = 1'b1; host.challenge_a = a; host.challenge_b = b;
    ev_done_cyc = -1; ev_ndone = 0; ev_busy_cyc = 0; ev_en_seen = 1'b0; ev_rst_mid = '1;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(posedge clk); #1;
      host.start = (c == restart_at);
      if (c == 1) begin host.challenge_a = b; host.challenge_b = a; end
      if (host.busy) ev_busy_cyc++;
      if (ro_en) ev_en_seen = 1'b1;
      if (c == RC + 10) ev_rst_mid = ro_rst;
      if (host.done) begin
        ev_ndone++;
        if (ev_done_cyc < 0) ev_done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (host.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", host.busy); end
    n_chk++; if (host.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", host.done); end
    n_chk++; if ({host.response, host.error, host.saturated} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got %b want 000", {host.response, host.error, host.saturated}); end
    n_chk++; if ({host.count_a, host.count_b} !== 32'h0) begin n_err++;
      $display("FAIL reset_counts: got %h/%h want 0/0", host.count_a, host.count_b); end
    n_chk++; if (ro_en !== 1'b0) begin n_err++; $display("FAIL reset_ro_enable: got %b want 0", ro_en); end
    n_chk++; if (ro_rst !== 8'hFF) begin n_err++; $display("FAIL reset_ro_rst: got %h want ff", ro_rst); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_periods(2, 4, 0, 0);
    run_eval(3'd0, 3'd1, -1);
    n_chk++; if (ev_done_cyc != DONE_CYC) begin n_err++; $display("FAIL basic_done_cycle: got %0d want %0d", ev_done_cyc, DONE_CYC); end
    n_chk++; if (ev_ndone != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", ev_ndone); end
    n_chk++; if (ev_busy_cyc != DONE_CYC) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want %0d", ev_busy_cyc, DONE_CYC); end
    n_chk++; if (host.count_a < 9 || host.count_a > 10) begin n_err++; $display("FAIL basic_count_a: got %0d want 9..10", host.count_a); end
    n_chk++; if (host.count_b < 4 || host.count_b > 5) begin n_err++; $display("FAIL basic_count_b: got %0d want 4..5", host.count_b); end
    n_chk++; if (host.response !== 1'b1) begin n_err++; $display("FAIL basic_response: got %b want 1", host.response); end
    n_chk++; if ({host.error, host.saturated} !== 2'b00) begin n_err++;
      $display("FAIL basic_err_sat: got %b want 00", {host.error, host.saturated}); end
    n_chk++; if (ev_rst_mid !== 8'hFC) begin n_err++; $display("FAIL basic_ro_rst_measure: got %h want fc", ev_rst_mid); end
  endtask

  task automatic test_swap_tie();
    set_periods(2, 4, 0, 0);
    run_eval(3'd1, 3'd0, -1);
    n_chk++; if (host.response !== 1'b0) begin n_err++; $display("FAIL swap_response: got %b want 0", host.response); end
    n_chk++; if (host.count_a < 4 || host.count_a > 5) begin n_err++; $display("FAIL swap_count_a: got %0d want 4..5", host.count_a); end
    set_periods(0, 0, 3, 0);
    tie_mode = 1'b1;
    run_eval(3'd2, 3'd3, -1);
    tie_mode = 1'b0;
    n_chk++; if (host.response !== 1'b0) begin n_err++; $display("FAIL tie_response: got %b want 0", host.response); end
    n_chk++; if (host.count_a !== host.count_b) begin n_err++; $display("FAIL tie_equal_counts: got %0d/%0d want equal", host.count_a, host.count_b); end
    n_chk++; if (host.count_a < edges_lo(3) || host.count_a > edges_hi(3)) begin n_err++;
      $display("FAIL tie_count: got %0d want %0d..%0d", host.count_a, edges_lo(3), edges_hi(3)); end
  endtask

  task automatic test_error();
    set_periods(2, 4, 0, 3);
    run_eval(3'd3, 3'd3, -1);
    n_chk++; if (ev_done_cyc != 1) begin n_err++; $display("FAIL error_done_cycle: got %0d want 1", ev_done_cyc); end
    n_chk++; if (ev_busy_cyc != 1) begin n_err++; $display("FAIL error_busy_cycles: got %0d want 1", ev_busy_cyc); end
    n_chk++; if (ev_en_seen !== 1'b0) begin n_err++; $display("FAIL error_ro_enable_seen: got %b want 0", ev_en_seen); end
    n_chk++; if ({host.error, host.response} !== 2'b10) begin n_err++;
      $display("FAIL error_flags: got %b want 10", {host.error, host.response}); end
    n_chk++; if ({host.count_a, host.count_b} !== 32'h0) begin n_err++;
      $display("FAIL error_counts: got %0d/%0d want 0/0", host.count_a, host.count_b); end
  endtask

  task automatic test_no_restart();
    set_periods(2, 4, 0, 0);
    run_eval(3'd0, 3'd1, RC + 15);
    n_chk++; if (ev_ndone != 1 || ev_done_cyc != DONE_CYC) begin n_err++;
      $display("FAIL restart_done: got %0d pulses at %0d want 1 at %0d", ev_ndone, ev_done_cyc, DONE_CYC); end
    n_chk++; if (host.response !== 1'b1 || host.error !== 1'b0) begin n_err++;
      $display("FAIL restart_result: got resp=%b err=%b want 1/0", host.response, host.error); end
    n_chk++; if (host.count_a < 9 || host.count_a > 10) begin n_err++; $display("FAIL restart_count_a: got %0d want 9..10", host.count_a); end
  endtask

  task automatic test_abort();
    int ndone;
    set_periods(2, 4, 0, 0);
    host.start = 1'b1; host.challenge_a = 3'd0; host.challenge_b = 3'd1;
    for (int c = 1; c <= RC + 20; c++) begin
      @(posedge clk); #1;
      host.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++; if (host.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", host.busy); end
    n_chk++; if (ro_rst !== 8'hFF || ro_en !== 1'b0) begin n_err++;
      $display("FAIL abort_ro: got rst=%h en=%b want ff/0", ro_rst, ro_en); end
    n_chk++; if (host.count_a !== 16'h0) begin n_err++; $display("FAIL abort_count_a: got %0d want 0", host.count_a); end
    ndone = 0;
    for (int c = 0; c < RUN_CYC; c++) begin
      if (host.done) ndone++;
      @(posedge clk); #1;
    end
    n_chk++; if (ndone != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    run_eval(3'd0, 3'd1, -1);
    n_chk++; if (ev_done_cyc != DONE_CYC || host.response !== 1'b1) begin n_err++;
      $display("FAIL abort_rerun: got done@%0d resp=%b want %0d/1", ev_done_cyc, host.response, DONE_CYC); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [2:0] a, b;
      logic [7:0] exp_rst;
      int pa, pb;
      a  = 3'($urandom_range(0, 7));
      b  = 3'((int'(a) + int'($urandom_range(1, 7))) % 8);
      pa = int'($urandom_range(1, 6));
      pb = int'($urandom_range(1, 6));
      for (int i = 0; i < 8; i++) period[i] = 0;
      period[a] = pa; period[b] = pb;
      exp_rst = 8'hFF; exp_rst[a] = 1'b0; exp_rst[b] = 1'b0;
      run_eval(a, b, -1);
      n_chk++; if (ev_done_cyc != DONE_CYC || host.error !== 1'b0) begin n_err++;
        $display("FAIL rand%0d_done: got done@%0d err=%b want %0d/0", it, ev_done_cyc, host.error, DONE_CYC); end
      n_chk++; if (host.count_a < edges_lo(pa) || host.count_a > edges_hi(pa)) begin n_err++;
        $display("FAIL rand%0d_count_a: got %0d want %0d..%0d", it, host.count_a, edges_lo(pa), edges_hi(pa)); end
      n_chk++; if (host.count_b < edges_lo(pb) || host.count_b > edges_hi(pb)) begin n_err++;
        $display("FAIL rand%0d_count_b: got %0d want %0d..%0d", it, host.count_b, edges_lo(pb), edges_hi(pb)); end
      n_chk++; if (ev_rst_mid !== exp_rst) begin n_err++;
        $display("FAIL rand%0d_ro_rst: got %h want %h", it, ev_rst_mid, exp_rst); end
      if (edges_lo(pa) > edges_hi(pb) || edges_hi(pa) < edges_lo(pb)) begin
        n_chk++; if (host.response !== (edges_lo(pa) > edges_hi(pb))) begin n_err++;
          $display("FAIL rand%0d_response: got %b want %b", it, host.response, edges_lo(pa) > edges_hi(pb)); end
      end
    end
  endtask

  task automatic test_saturate();
    int done_cyc;
    logic [7:0] rst_mid;
    set_periods(1, 4, 0, 0);
    done_cyc = -1; rst_mid = '1;
    host_s.start = 1'b1; host_s.challenge_a = 3'd0; host_s.challenge_b = 3'd1;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(posedge clk); #1;
      host_s.start = 1'b0;
      if (c == RC + 12) rst_mid = ro_rst_s;
      if (host_s.done && done_cyc < 0) done_cyc = c;
    end
    n_chk++; if (done_cyc != DONE_CYC) begin n_err++; $display("FAIL sat_done_cycle: got %0d want %0d", done_cyc, DONE_CYC); end
    n_chk++; if (host_s.count_a !== 4'd15) begin n_err++; $display("FAIL sat_count_a: got %0d want 15", host_s.count_a); end
    n_chk++; if (host_s.saturated !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", host_s.saturated); end
    n_chk++; if (host_s.count_b < 4 || host_s.count_b > 5 || host_s.response !== 1'b1) begin n_err++;
      $display("FAIL sat_count_b_resp: got %0d resp=%b want 4..5/1", host_s.count_b, host_s.response); end
    n_chk++; if (rst_mid !== 8'hFC) begin n_err++; $display("FAIL sat_ro_rst_measure: got %h want fc", rst_mid); end
  endtask

  initial begin
    host.start = 1'b0;   host.challenge_a = '0;   host.challenge_b = '0;
    host_s.start = 1'b0; host_s.challenge_a = '0; host_s.challenge_b = '0;
    for (int i = 0; i < 8; i++) begin period[i] = 0; ro_cnt[i] = 0; end
    test_reset();
    test_basic();
    test_swap_tie();
    test_error();
    test_no_restart();
    test_abort();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
